// File: rtl/alu_seq_top_if.sv
// Handshake and operand/result bundle for the sequential ALU.
// The producer/consumer side uses master; the execution unit uses slave.
interface alu_seq_top_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [5:0]       opUAL;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Rez;
   logic [WIDTH-1:0] Hi;
   logic             CO;
   logic             OV;
   logic             Z;
   logic             busy;

   modport master (
      output in_valid, A, B, opUAL, out_ready,
      input  in_ready, out_valid, Rez, Hi,
      input  CO, OV, Z, busy
   );

   modport slave (
      input  in_valid, A, B, opUAL, out_ready,
      output in_ready, out_valid, Rez, Hi,
      output CO, OV, Z, busy
   );
endinterface

// File: rtl/alu_seq_top.sv
// Registered execution unit: ALU, XOR, shifts and a radix-2
// shift-add multiplier with a double-width Hi/Lo product.
module alu_seq_top #(
   parameter int WIDTH = 32,
   parameter int SH_W  = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          rst,
   alu_seq_top_if.slave bus
);
   localparam int W2 = 2 * WIDTH;
   localparam int M  = WIDTH - 1;
   localparam logic [SH_W-1:0] LAST = SH_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] rez_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] ma_q;
   logic [W2-1:0]    prod_q;
   logic [SH_W-1:0]  cnt_q;
   logic             neg_q;
   logic             co_q;
   logic             ov_q;
   logic             z_q;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       unit;
   logic [3:0]       sub;
   logic [SH_W-1:0]  sh;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [WIDTH-1:0] res_d;
   logic             co_d;
   logic             ov_d;
   logic             sgn_mode;
   logic [WIDTH-1:0] amag;
   logic [WIDTH-1:0] bmag;
   logic             sgn;
   logic [WIDTH:0]   msum;
   logic [W2-1:0]    pstep;
   logic [W2-1:0]    pfin;

   assign a    = bus.A;
   assign b    = bus.B;
   assign unit = bus.opUAL[5:4];
   assign sub  = bus.opUAL[3:0];
   assign sh   = b[SH_W-1:0];

   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} + {1'b0, ~b}
                + (WIDTH+1)'(1);

   always_comb begin
      res_d = '0;
      co_d  = 1'b0;
      ov_d  = 1'b0;
      unique case (1'b1)
         (unit == 2'b00): begin
            case (sub)
               4'b0000: res_d = a & b;
               4'b0001: res_d = a | b;
               4'b0010: begin
                  res_d = add_w[M:0];
                  co_d  = add_w[WIDTH];
                  ov_d  = (a[M] == b[M]) &&
                          (add_w[M] != a[M]);
               end
               4'b0110: begin
                  res_d = sub_w[M:0];
                  co_d  = sub_w[WIDTH];
                  ov_d  = (a[M] != b[M]) &&
                          (sub_w[M] != a[M]);
               end
               4'b0111: res_d = {{M{1'b0}},
                  ($signed(a) < $signed(b))};
               4'b1100: res_d = ~(a | b);
               default: res_d = '0;
            endcase
         end
         (unit == 2'b10): res_d = a ^ b;
         (unit == 2'b11): begin
            case (sub[1:0])
               2'b00:   res_d = a << sh;
               2'b01:   res_d = a >> sh;
               2'b10:   res_d = $signed(a) >>> sh;
               default: res_d = a << 2;
            endcase
         end
         default: res_d = '0;
      endcase
   end

   // Magnitudes stay WIDTH-bit unsigned so -2^(W-1) survives.
   assign sgn_mode = bus.opUAL[0];
   assign amag = (sgn_mode && a[M]) ? -a : a;
   assign bmag = (sgn_mode && b[M]) ? -b : b;
   assign sgn  = sgn_mode && (a[M] ^ b[M]);

   assign msum  = {1'b0, prod_q[W2-1:WIDTH]}
                + {1'b0, (prod_q[0] ? ma_q : '0)};
   assign pstep = {msum, prod_q[WIDTH-1:1]};
   assign pfin  = neg_q ? -pstep : pstep;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rez_q   <= '0;
         hi_q    <= '0;
         ma_q    <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (unit == 2'b01) begin
                     ma_q    <= amag;
                     prod_q  <= {{WIDTH{1'b0}}, bmag};
                     neg_q   <= sgn;
                     cnt_q   <= '0;
                     state_q <= MUL;
                  end else begin
                     rez_q   <= res_d;
                     hi_q    <= '0;
                     co_q    <= co_d;
                     ov_q    <= ov_d;
                     z_q     <= (res_d == '0);
                     state_q <= DONE;
                  end
               end
            end
            MUL: begin
               prod_q <= pstep;
               cnt_q  <= cnt_q + SH_W'(1);
               if (cnt_q == LAST) begin
                  {hi_q, rez_q} <= pfin;
                  co_q    <= 1'b0;
                  ov_q    <= 1'b0;
                  z_q     <= (pfin == '0);
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == MUL);
   assign bus.Rez       = rez_q;
   assign bus.Hi        = hi_q;
   assign bus.CO        = co_q;
   assign bus.OV        = ov_q;
   assign bus.Z         = z_q;
endmodule

// File: tb/tb_alu_seq_top.sv
// Directed bench for alu_seq_top at WIDTH=32 and WIDTH=16.
module tb_alu_seq_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   lat;
   int   nb;

   always #5 clk = ~clk;

   alu_seq_top_if #(.WIDTH(32)) b32 ();
   alu_seq_top_if #(.WIDTH(16)) b16 ();

   alu_seq_top #(.WIDTH(32)) u32 (
      .clk (clk),
      .rst (rst),
      .bus (b32.slave)
   );

   alu_seq_top #(.WIDTH(16)) u16 (
      .clk (clk),
      .rst (rst),
      .bus (b16.slave)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag,
                          input logic [31:0] rez,
                          input logic [31:0] hi,
                          input logic [2:0] fl);
      check({tag, "_rez"}, 64'(b32.Rez), 64'(rez));
      check({tag, "_hi"}, 64'(b32.Hi), 64'(hi));
      check({tag, "_flags"},
            64'({b32.CO, b32.OV, b32.Z}), 64'(fl));
      check({tag, "_vld"}, 64'(b32.out_valid), 64'(1));
   endtask

   task automatic issue(input logic [5:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit pulse,
                        output int l,
                        output int n);
      int w;
      w = 0;
      while (!b32.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_wait", 64'(w < 50), 64'(1));
      b32.opUAL    = op;
      b32.A        = a;
      b32.B        = b;
      b32.in_valid = 1'b1;
      @(negedge clk);
      b32.in_valid = 1'b0;
      l = 1;
      n = 0;
      while (!b32.out_valid && l < 100) begin
         if (b32.busy) n++;
         if (pulse) begin
            b32.opUAL    = 6'h02;
            b32.in_valid = b32.busy;
         end
         @(negedge clk);
         l++;
      end
      b32.in_valid = 1'b0;
   endtask

   task automatic consume();
      b32.out_ready = 1'b1;
      @(negedge clk);
      b32.out_ready = 1'b0;
      check("drop_vld", 64'(b32.out_valid), 64'(0));
   endtask

   initial begin
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b0;
      b32.A         = '0;
      b32.B         = '0;
      b32.opUAL     = '0;
      b16.in_valid  = 1'b0;
      b16.out_ready = 1'b0;
      b16.A         = '0;
      b16.B         = '0;
      b16.opUAL     = '0;

      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(b32.in_ready), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rst_rez", 64'(b32.Rez), 64'(0));
      check("rst_hi", 64'(b32.Hi), 64'(0));
      check("rst_flags",
            64'({b32.CO, b32.OV, b32.Z}), 64'(0));
      check("rst_vld", 64'(b32.out_valid), 64'(0));
      check("rst_busy", 64'(b32.busy), 64'(0));
      check("rst_rdy", 64'(b32.in_ready), 64'(1));

      issue(6'h02, 32'h7FFF_FFFF, 32'h1, 0, lat, nb);
      check("add_lat", 64'(lat), 64'(1));
      chk_res("add", 32'h8000_0000, 0, 3'b010);
      consume();

      issue(6'h06, 32'd5, 32'd5, 0, lat, nb);
      chk_res("sub", 32'h0, 0, 3'b101);
      consume();

      issue(6'h07, 32'hFFFF_FFFF, 32'h1, 0, lat, nb);
      chk_res("slt", 32'h1, 0, 3'b000);
      consume();

      issue(6'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 0, lat, nb);
      chk_res("and", 32'h00F0_1200, 0, 3'b000);
      consume();
      issue(6'h01, 32'hF0F0_1234, 32'h0FF0_FF00, 0, lat, nb);
      chk_res("or", 32'hFFF0_FF34, 0, 3'b000);
      consume();
      issue(6'h0C, 32'hF0F0_1234, 32'h0FF0_FF00, 0, lat, nb);
      chk_res("nor", 32'h000F_00CB, 0, 3'b000);
      consume();
      issue(6'h03, 32'h1234_5678, 32'h1, 0, lat, nb);
      chk_res("badop", 32'h0, 0, 3'b001);
      consume();
      issue(6'h20, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, lat, nb);
      chk_res("xor", 32'h5A5A_A5A5, 0, 3'b000);
      consume();

      issue(6'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat, nb);
      check("umul_busy", 64'(nb), 64'(32));
      check("umul_lat", 64'(lat), 64'(33));
      chk_res("umul", 32'h0000_0001, 32'hFFFF_FFFE, 3'b000);
      consume();
      repeat (3) begin
         @(negedge clk);
         check("no_extra", 64'(b32.out_valid), 64'(0));
      end

      issue(6'h11, -32'sd7, 32'd3, 0, lat, nb);
      chk_res("smul", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 3'b000);
      for (int i = 0; i < 10; i++) begin
         b32.in_valid = 1'b1;
         b32.opUAL    = 6'h02;
         @(negedge clk);
         b32.in_valid = 1'b0;
         chk_res("stall", 32'hFFFF_FFEB, 32'hFFFF_FFFF,
                 3'b000);
      end
      consume();

      issue(6'h11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, nb);
      chk_res("smin", 32'h8000_0000, 32'h0, 3'b000);
      consume();

      issue(6'h30, 32'h8000_0010, 32'd4, 0, lat, nb);
      chk_res("sll", 32'h0000_0100, 0, 3'b000);
      consume();
      issue(6'h31, 32'h8000_0010, 32'd4, 0, lat, nb);
      chk_res("srl", 32'h0800_0001, 0, 3'b000);
      consume();
      issue(6'h32, 32'h8000_0010, 32'd4, 0, lat, nb);
      chk_res("sra", 32'hF800_0001, 0, 3'b000);
      consume();
      issue(6'h33, 32'h8000_0010, 32'd4, 0, lat, nb);
      chk_res("sll2", 32'h0000_0040, 0, 3'b000);
      consume();

      b32.opUAL    = 6'h10;
      b32.A        = 32'hFFFF_FFFF;
      b32.B        = 32'hFFFF_FFFF;
      b32.in_valid = 1'b1;
      @(negedge clk);
      b32.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", 64'(b32.busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_busy", 64'(b32.busy), 64'(0));
      check("mr_vld", 64'(b32.out_valid), 64'(0));
      check("mr_rez", 64'(b32.Rez), 64'(0));
      check("mr_hi", 64'(b32.Hi), 64'(0));
      check("mr_flags",
            64'({b32.CO, b32.OV, b32.Z}), 64'(0));
      @(negedge clk);
      check("mr_rdy", 64'(b32.in_ready), 64'(1));

      issue(6'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, nb);
      check("remul_busy", 64'(nb), 64'(32));
      check("remul_lat", 64'(lat), 64'(33));
      chk_res("remul", 32'h0000_0001, 32'hFFFF_FFFE, 3'b000);
      consume();

      check("w16_rdy", 64'(b16.in_ready), 64'(1));
      b16.opUAL    = 6'h10;
      b16.A        = 16'hFFFF;
      b16.B        = 16'hFFFF;
      b16.in_valid = 1'b1;
      @(negedge clk);
      b16.in_valid = 1'b0;
      lat = 1;
      nb  = 0;
      while (!b16.out_valid && lat < 100) begin
         if (b16.busy) nb++;
         @(negedge clk);
         lat++;
      end
      check("w16_busy", 64'(nb), 64'(16));
      check("w16_lat", 64'(lat), 64'(17));
      check("w16_rez", 64'(b16.Rez), 64'(16'h0001));
      check("w16_hi", 64'(b16.Hi), 64'(16'hFFFE));
      check("w16_z", 64'(b16.Z), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq_top.md
# alu_seq_top

Parametrised, handshaked execution unit for the MIPS datapath. Replaces the purely combinational ALU top with a registered unit that adds variable shifts and a multi-cycle signed/unsigned multiplier producing a full double-width product (Hi/Lo). Sits between the decode/operand stage and write-back. A valid/ready interface lets the pipeline stall while a multiply is in flight.

## Interface
- WIDTH, 32: operand and result width; must be a power of two, at least 8.
- SH_W, $clog2(WIDTH): width of the shift-amount field taken from B.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  unit can accept; high only in IDLE.
- A, B  in  WIDTH each  operands.
- opUAL  in  6  [5:4] unit select, [3:0] sub-op.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- Rez  out  WIDTH  result (low half of product for multiply).
- Hi  out  WIDTH  high half of product; 0 for non-multiply ops.
- CO, OV, Z  out  1 each  carry, signed overflow, zero flags.
- busy  out  1  high in MUL state.

## Operation
- Opcode map:
  - unit 00 = ALU. Sub-ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR. Any other sub-op gives Rez=0 and all flags 0 except Z=1.
  - unit 01 = multiply. opUAL[0]=1 signed, 0 unsigned.
  - unit 10 = XOR.
  - unit 11 = shift. opUAL[1:0]: 00 SLL by B[SH_W-1:0], 01 SRL, 10 SRA, 11 SLL by fixed 2 (legacy).
- Flags:
  - CO is the carry-out of A+B (ADD) or of A+~B+1 (SUB). OV is signed overflow for ADD/SUB.
  - CO and OV are 0 for every other op.
  - Z is 1 when the full result is zero: {Hi,Rez} for multiply, Rez otherwise.
- FSM states IDLE, MUL, DONE:
  - IDLE: in_ready=1. On in_valid, a non-multiply op computes and registers Rez/Hi/flags, then goes to DONE. A multiply latches |A|, |B| (signed mode) or A, B as-is, plus the result sign, then goes to MUL.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles counted by an internal counter. On the last iteration the product is two's-complement negated if the sign is negative, registered, then the FSM goes to DONE.
  - DONE: out_valid=1 and outputs held stable. When out_ready=1, go to IDLE. out_valid drops the next cycle.
- in_valid outside IDLE is ignored; no operand is captured.
- Signed edge case: the most negative operand times -1 must give the correct 2W-bit product, 2^(WIDTH-1) positive. The magnitude path must therefore be WIDTH bits, treated as unsigned.
- Reset:
  - Reset mid-operation (any state) aborts, returns to IDLE, and zeroes the counter.
  - Reset values: Rez=0, Hi=0, CO=0, OV=0, Z=0, out_valid=0, busy=0, in_ready=0 during the reset cycle, then 1.

## Timing
- Non-multiply op: accepted on edge N. out_valid=1 after edge N+1, in the cycle following acceptance.
- Multiply: accepted on edge N. busy=1 for cycles N+1..N+WIDTH. out_valid=1 after edge N+WIDTH+1 (33 cycles for WIDTH=32).
- Back-to-back throughput, with out_ready held high: one op per 2 cycles for non-multiply ops, one per WIDTH+2 cycles for multiply.
- out_ready low in DONE stalls indefinitely. Outputs must not change while stalled.
- in_ready depends only on state. It has no combinational path from out_ready.

## Test plan
- Reset then ADD 0x7FFFFFFF + 0x00000001 -> one cycle later out_valid=1, Rez=0x80000000, OV=1, CO=0, Z=0.
- SUB 5-5, then SLT 0xFFFFFFFF vs 0x00000001 -> first result Rez=0, Z=1, CO=1, OV=0. Second result Rez=1, Z=0.
- Unsigned multiply 0xFFFFFFFF x 0xFFFFFFFF -> busy for exactly 32 cycles, then Hi=0xFFFFFFFE, Rez=0x00000001, Z=0. in_valid pulses during busy produce no extra results.
- Signed multiply -7 x 3 -> Hi=0xFFFFFFFF, Rez=0xFFFFFFEB. Signed 0x80000000 x 0xFFFFFFFF -> Hi=0x00000000, Rez=0x80000000.
- Shifts on A=0x80000010, B=4:
  - SLL -> 0x00000100
  - SRL -> 0x08000001
  - SRA -> 0xF8000001
  - legacy SLL2 -> 0x00000040
- Stall and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable.
  - Assert rst in MUL cycle 5 -> next cycle IDLE, all outputs 0.
  - Re-issue the multiply -> correct result, with full 32-cycle latency.
  - Also run WIDTH=16: 0xFFFF x 0xFFFF unsigned -> Hi=0xFFFE, Rez=0x0001 after 16 busy cycles.
